// File: rtl/uart_loopback_monitor.sv
// uart_loopback_monitor: debounced send button issues a UART byte and checks its loopback echo.
module uart_loopback_monitor #(
    parameter int DATA_BITS       = 8,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 100_000
) (
    input  logic                       CLOCK_100,
    input  logic                       reset,
    input  logic [DATA_BITS-1:0]       rx_data,
    input  logic                       rx_valid,
    input  logic                       send_req,
    input  logic [DATA_BITS-1:0]       send_data,
    input  logic                       tx_busy,
    output logic [DATA_BITS-1:0]       tx_data,
    output logic                       tx_send,
    output logic [DEPTH*DATA_BITS-1:0] history,
    output logic [15:0]                rx_count,
    output logic [15:0]                match_count,
    output logic [15:0]                err_count,
    output logic                       mismatch,
    output logic                       timeout,
    output logic                       state_busy
);
    localparam int HW = DEPTH * DATA_BITS;
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ECHO} state_t;

    state_t         state;
    logic           sync1, sync2, deb, pending;
    logic [DW-1:0]  deb_cnt;
    logic [TW-1:0]  timer;
    logic           deb_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction

    assign deb_done   = sync2 != deb && deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign state_busy = state != IDLE;

    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            deb         <= 1'b0;
            deb_cnt     <= '0;
            pending     <= 1'b0;
            timer       <= '0;
            tx_data     <= '0;
            tx_send     <= 1'b0;
            history     <= '0;
            rx_count    <= '0;
            match_count <= '0;
            err_count   <= '0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            sync1   <= send_req;
            sync2   <= sync1;
            deb_cnt <= sync2 == deb || deb_done ? '0 : deb_cnt + 1'b1;
            if (deb_done) deb <= sync2;
            // Only one request is remembered; rises while pending are dropped.
            if (deb_done && sync2) pending <= 1'b1;
            tx_send <= 1'b0;
            if (rx_valid) begin
                history  <= (history << DATA_BITS) | HW'(rx_data);
                rx_count <= sat_inc(rx_count);
            end
            case (state)
                IDLE: if (pending && !tx_busy) state <= ISSUE;
                ISSUE: begin
                    tx_data <= send_data;
                    tx_send <= 1'b1;
                    pending <= 1'b0;
                    timer   <= TW'(TIMEOUT_CYCLES);
                    state   <= WAIT_ECHO;
                end
                WAIT_ECHO: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (rx_valid) begin
                        if (rx_data == tx_data) match_count <= sat_inc(match_count);
                        else begin
                            mismatch  <= 1'b1;
                            err_count <= sat_inc(err_count);
                        end
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                        if (timer == TW'(1)) begin
                            timeout   <= 1'b1;
                            err_count <= sat_inc(err_count);
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_loopback_monitor.md
UART_LOOPBACK_MONITOR -- requirements
Module: uart_loopback_monitor

Interface
REQ-001 Parameter: DATA_BITS, default 8, width of UART data bytes.
REQ-002 Parameter: DEPTH, default 4, number of received bytes retained in the history buffer (DEPTH >= 1).
REQ-003 Parameter: DEBOUNCE_CYCLES, default 1_000_000, number of consecutive stable samples needed to accept a send_req level change (>= 1).
REQ-004 Parameter: TIMEOUT_CYCLES, default 100_000, maximum cycles to wait for a loopback echo (>= 1).
REQ-005 Port: CLOCK_100  in  1  sole clock; all logic rises on its posedge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: rx_data  in  DATA_BITS  byte from UART receiver; valid only when rx_valid=1.
REQ-008 Port: rx_valid  in  1  one-cycle strobe marking a received byte.
REQ-009 Port: send_req  in  1  raw, asynchronous, bouncy button level requesting a transmit.
REQ-010 Port: send_data  in  DATA_BITS  byte to transmit; sampled when the send is issued.
REQ-011 Port: tx_busy  in  1  UART transmitter busy.
REQ-012 Port: tx_data  out  DATA_BITS  byte presented to the transmitter; held stable from issue until the next issue.
REQ-013 Port: tx_send  out  1  one-cycle transmit strobe.
REQ-014 Port: history  out  DEPTH*DATA_BITS  received bytes; slice [DATA_BITS-1:0] holds the newest byte.
REQ-015 Port: rx_count  out  16  saturating count of rx_valid strobes.
REQ-016 Port: match_count  out  16  saturating count of correct echoes.
REQ-017 Port: err_count  out  16  saturating count of mismatches plus timeouts.
REQ-018 Port: mismatch  out  1  sticky flag: echoed byte differed from tx_data.
REQ-019 Port: timeout  out  1  sticky flag: no echo within TIMEOUT_CYCLES.
REQ-020 Port: state_busy  out  1  high while the FSM is outside IDLE.

Function
REQ-021 send_req shall pass through a 2-flop synchronizer before use.
REQ-022 The debouncer shall change its output only after the synchronized level differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any reversion shall clear the counter.
REQ-023 A debounced 0->1 transition shall set a pending flag; further transitions while pending is set shall be ignored (no queueing beyond one request).
REQ-024 FSM states shall be IDLE, ISSUE and WAIT_ECHO.
REQ-025 In IDLE with pending=1 and tx_busy=0, the FSM shall move to ISSUE; with tx_busy=1 it shall remain in IDLE with pending held.
REQ-026 In ISSUE (exactly one cycle), tx_data shall load send_data, tx_send shall be 1, pending shall clear, the timer shall load TIMEOUT_CYCLES, and the next state shall be WAIT_ECHO.
REQ-027 In WAIT_ECHO, on rx_valid=1: rx_data==tx_data increments match_count, otherwise sets mismatch and increments err_count; next state IDLE.
REQ-028 In WAIT_ECHO without rx_valid, the timer shall decrement each cycle; on reaching 0 it shall set timeout, increment err_count and go to IDLE.
REQ-029 If rx_valid coincides with timer expiry, the byte shall be compared (REQ-027) and no timeout shall be recorded.
REQ-030 Each rx_valid strobe in any state shall shift history by one entry (entry i <= entry i-1, entry 0 <= rx_data, oldest discarded) and shall increment rx_count.
REQ-031 All counters shall saturate at 16'hFFFF and never wrap.
REQ-032 mismatch and timeout shall remain set until reset.
REQ-033 tx_send shall never be high for two consecutive cycles.

Reset
REQ-034 When reset=1 at a clock edge: FSM -> IDLE; pending, tx_send, mismatch, timeout, state_busy = 0; tx_data, history, all counters = 0; debounced level, synchronizer and debounce counter = 0.
REQ-035 A reset asserted in ISSUE or WAIT_ECHO shall abort the transaction without counting a match, mismatch or timeout.

Verification
REQ-036 DEBOUNCE_CYCLES=4: send_req high with send_data=8'hA5, tx_busy=0 -> exactly one tx_send pulse within 8 cycles, tx_data=8'hA5.
REQ-037 After issue, rx_valid with rx_data=8'hA5 after 10 cycles -> match_count=1, err_count=0, history[7:0]=8'hA5, rx_count=1.
REQ-038 Echo 8'h5A against tx_data=8'hA5 -> mismatch=1, err_count=1; with TIMEOUT_CYCLES=16 and no echo -> timeout=1 exactly 16 cycles after ISSUE.
REQ-039 send_req glitching high for 3 cycles with DEBOUNCE_CYCLES=4 -> no tx_send; request held while tx_busy=1 -> tx_send in the cycle after ISSUE following tx_busy fall.
REQ-040 DEPTH=4: push 8'h01..8'h05 -> history=32'h02030405; rx_valid coincident with timer expiry -> compare only, timeout=0; reset in WAIT_ECHO -> all outputs 0, no counter change afterwards.
